// File: rtl/sfp_supervisor_pkg.sv
// Shared types and timing constants for the SFP quad supervisor.
package sfp_supervisor_pkg;

  localparam int RESET_PULSE_CYCLES = 16;
  localparam int LOCK_STABLE_CYCLES = 64;

  typedef enum logic [1:0] {
    QPLL_RESET,
    QPLL_WAIT_LOCK,
    QPLL_LOCKED,
    QPLL_FAULT
  } qpll_state_t;

  typedef enum logic [2:0] {
    LANE_DISABLED,
    LANE_WAIT_PLL,
    LANE_WAIT_SIGNAL,
    LANE_SERDES_RST,
    LANE_ACTIVE
  } lane_state_t;

endpackage

// File: rtl/sfp_lane_fsm.sv
// One SFP lane: LOS / module-absent debouncers, bring-up FSM, rate select and flap counter.
// Optional macro SFP_SUPERVISOR_TX_SQUELCH_EN keeps the laser dark until SERDES_RST/ACTIVE.
module sfp_lane_fsm
  import sfp_supervisor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 156250,
  parameter int FLAP_WIDTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pll_locked_i,
  input  logic                  rx_los_i,
  input  logic                  mod_abs_i,
  input  logic                  lane_en_i,
  input  logic [1:0]            rate_sel_i,
  input  logic                  link_up_i,
  input  logic                  flap_clear_i,
  output logic                  tx_disable_o,
  output logic [1:0]            rs_o,
  output logic                  serdes_rst_o,
  output logic                  ready_o,
  output logic [FLAP_WIDTH-1:0] flap_count_o
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0] raw_in;
  logic [1:0] filt;
  logic       los_filt;
  logic       abs_filt;

  assign raw_in   = {mod_abs_i, rx_los_i};
  assign los_filt = filt[0];
  assign abs_filt = filt[1];

  // Any change of the raw pin restarts the count; the filtered value follows after a full quiet window.
  for (genvar gi = 0; gi < 2; gi++) begin : g_db
    logic          raw_q;
    logic          filt_q;
    logic [DW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        raw_q  <= 1'b1;
        filt_q <= 1'b1;
        cnt_q  <= '0;
      end else begin
        raw_q <= raw_in[gi];
        if (raw_in[gi] != raw_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          filt_q <= raw_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign filt[gi] = filt_q;
  end

  lane_state_t           state_q, state_d;
  logic [3:0]            rst_cnt_q, rst_cnt_d;
  logic [1:0]            rs_q;
  logic                  link_q;
  logic [FLAP_WIDTH-1:0] flap_q, flap_d;
  logic                  rate_change;
  logic                  link_fall;

  assign rate_change = (rate_sel_i != rs_q);
  assign link_fall   = link_q && !link_up_i && (state_q == LANE_ACTIVE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= LANE_DISABLED;
      rst_cnt_q <= '0;
      rs_q      <= '0;
      link_q    <= 1'b0;
      flap_q    <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      rs_q      <= rate_sel_i;
      link_q    <= link_up_i;
      flap_q    <= flap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    if (!lane_en_i) begin
      state_d = LANE_DISABLED;
    end else if (!pll_locked_i) begin
      state_d = LANE_WAIT_PLL;
    end else if ((state_q == LANE_SERDES_RST || state_q == LANE_ACTIVE) && (abs_filt || los_filt)) begin
      state_d = LANE_WAIT_SIGNAL;
    end else begin
      case (state_q)
        LANE_DISABLED:    state_d = LANE_WAIT_PLL;
        LANE_WAIT_PLL:    state_d = LANE_WAIT_SIGNAL;
        LANE_WAIT_SIGNAL: begin
          if (!abs_filt && !los_filt) begin
            state_d   = LANE_SERDES_RST;
            rst_cnt_d = '0;
          end
        end
        LANE_SERDES_RST: begin
          // A new rate mid-reset starts the hold over so the datapath sees a full pulse.
          if (rate_change) begin
            rst_cnt_d = '0;
          end else if (rst_cnt_q == 4'(RESET_PULSE_CYCLES - 1)) begin
            state_d = LANE_ACTIVE;
          end else begin
            rst_cnt_d = rst_cnt_q + 4'd1;
          end
        end
        LANE_ACTIVE: begin
          if (rate_change) begin
            state_d   = LANE_SERDES_RST;
            rst_cnt_d = '0;
          end
        end
        default: state_d = LANE_DISABLED;
      endcase
    end
  end

  always_comb begin
    flap_d = flap_q;
    if (flap_clear_i) begin
      flap_d = '0;
    end else if (link_fall && (flap_q != '1)) begin
      flap_d = flap_q + 1'b1;
    end
  end

  assign serdes_rst_o = (state_q != LANE_ACTIVE);
  assign ready_o      = (state_q == LANE_ACTIVE);
  assign rs_o         = rs_q;
  assign flap_count_o = flap_q;

`ifdef SFP_SUPERVISOR_TX_SQUELCH_EN
  assign tx_disable_o = !(state_q == LANE_SERDES_RST || state_q == LANE_ACTIVE);
`else
  assign tx_disable_o = (state_q == LANE_DISABLED) || abs_filt;
`endif

endmodule

// File: rtl/sfp_quad_supervisor.sv
// GTY quad supervisor: two QPLL lock/retry FSMs plus one sfp_lane_fsm per SFP cage.
// Optional macro SFP_SUPERVISOR_TX_SQUELCH_EN (handled inside sfp_lane_fsm).
module sfp_quad_supervisor
  import sfp_supervisor_pkg::*;
#(
  parameter int NUM_LANES       = 4,
  parameter int DEBOUNCE_CYCLES = 156250,
  parameter int LOCK_TIMEOUT    = 1562500,
  parameter int MAX_RETRIES     = 3,
  parameter int FLAP_WIDTH      = 16
) (
  input  logic                            clk_sys,
  input  logic                            rst,
  input  logic [1:0]                      qpll_lock,
  output logic [1:0]                      qpll_reset,
  output logic [1:0]                      qpll_fault,
  input  logic [NUM_LANES-1:0]            sfp_rx_los,
  input  logic [NUM_LANES-1:0]            sfp_mod_abs,
  output logic [NUM_LANES-1:0]            sfp_tx_disable,
  output logic [2*NUM_LANES-1:0]          sfp_rs,
  input  logic [NUM_LANES-1:0]            cfg_lane_en,
  input  logic [2*NUM_LANES-1:0]          cfg_rate_sel,
  input  logic [NUM_LANES-1:0]            lane_link_up,
  output logic [NUM_LANES-1:0]            lane_serdes_rst,
  output logic [NUM_LANES-1:0]            lane_ready,
  output logic [FLAP_WIDTH*NUM_LANES-1:0] flap_count,
  input  logic [NUM_LANES-1:0]            flap_clear
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  logic qpll0_locked;

  for (genvar gi = 0; gi < 2; gi++) begin : g_qpll
    qpll_state_t   state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retries_q, retries_d;

    always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
        state_q   <= QPLL_RESET;
        cnt_q     <= '0;
        timer_q   <= '0;
        retries_q <= '0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        timer_q   <= timer_d;
        retries_q <= retries_d;
      end
    end

    // cnt_q doubles as the reset-pulse length and the consecutive-lock run length.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timer_d   = timer_q;
      retries_d = retries_q;
      case (state_q)
        QPLL_RESET: begin
          if (cnt_q == 7'(RESET_PULSE_CYCLES - 1)) begin
            state_d = QPLL_WAIT_LOCK;
            cnt_d   = '0;
            timer_d = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        QPLL_WAIT_LOCK: begin
          timer_d = timer_q + TW'(1);
          cnt_d   = qpll_lock[gi] ? cnt_q + 7'd1 : 7'd0;
          if (qpll_lock[gi] && cnt_q == 7'(LOCK_STABLE_CYCLES - 1)) begin
            state_d   = QPLL_LOCKED;
            retries_d = '0;
          end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
            cnt_d     = '0;
            retries_d = retries_q + RW'(1);
            state_d   = (retries_q == RW'(MAX_RETRIES - 1)) ? QPLL_FAULT : QPLL_RESET;
          end
        end
        QPLL_LOCKED: begin
          if (!qpll_lock[gi]) begin
            state_d   = QPLL_RESET;
            cnt_d     = '0;
            retries_d = '0;
          end
        end
        QPLL_FAULT: state_d = QPLL_FAULT;
        default:    state_d = QPLL_RESET;
      endcase
    end

    assign qpll_reset[gi] = (state_q == QPLL_RESET);
    assign qpll_fault[gi] = (state_q == QPLL_FAULT);

    if (gi == 0) begin : g_lock0
      assign qpll0_locked = (state_q == QPLL_LOCKED);
    end
  end

  // QPLL1 is supervised above but deliberately never gates the lanes.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    sfp_lane_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .FLAP_WIDTH     (FLAP_WIDTH)
    ) u_lane (
      .clk_i        (clk_sys),
      .rst_i        (rst),
      .pll_locked_i (qpll0_locked),
      .rx_los_i     (sfp_rx_los[gi]),
      .mod_abs_i    (sfp_mod_abs[gi]),
      .lane_en_i    (cfg_lane_en[gi]),
      .rate_sel_i   (cfg_rate_sel[2*gi +: 2]),
      .link_up_i    (lane_link_up[gi]),
      .flap_clear_i (flap_clear[gi]),
      .tx_disable_o (sfp_tx_disable[gi]),
      .rs_o         (sfp_rs[2*gi +: 2]),
      .serdes_rst_o (lane_serdes_rst[gi]),
      .ready_o      (lane_ready[gi]),
      .flap_count_o (flap_count[FLAP_WIDTH*gi +: FLAP_WIDTH])
    );
  end

endmodule

// File: tb/tb_sfp_quad_supervisor.sv
// Self-checking bench for sfp_quad_supervisor: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the supervisor rules.
module tb_sfp_quad_supervisor;

  localparam int NL = 4;
  localparam int DB = 8;
  localparam int LT = 200;
  localparam int MR = 3;
  localparam int FW = 4;
  localparam int VW = 4 + 5 * NL + FW * NL;

  localparam int Q_RESET = 0, Q_WAIT = 1, Q_LOCKED = 2, Q_FAULT = 3;
  localparam int L_DIS = 0, L_WPLL = 1, L_WSIG = 2, L_SRST = 3, L_ACT = 4;

  logic              clk_sys = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        qpll_lock = '0;
  logic [1:0]        qpll_reset, qpll_fault;
  logic [NL-1:0]     sfp_rx_los = '1, sfp_mod_abs = '1, sfp_tx_disable;
  logic [2*NL-1:0]   sfp_rs, cfg_rate_sel = '0;
  logic [NL-1:0]     cfg_lane_en = '0, lane_link_up = '0, flap_clear = '0;
  logic [NL-1:0]     lane_serdes_rst, lane_ready;
  logic [FW*NL-1:0]  flap_count;
  logic [VW-1:0]     dut_vec;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_sys = ~clk_sys;

  sfp_quad_supervisor #(
    .NUM_LANES(NL), .DEBOUNCE_CYCLES(DB), .LOCK_TIMEOUT(LT), .MAX_RETRIES(MR), .FLAP_WIDTH(FW)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .qpll_lock(qpll_lock), .qpll_reset(qpll_reset),
    .qpll_fault(qpll_fault), .sfp_rx_los(sfp_rx_los), .sfp_mod_abs(sfp_mod_abs),
    .sfp_tx_disable(sfp_tx_disable), .sfp_rs(sfp_rs), .cfg_lane_en(cfg_lane_en),
    .cfg_rate_sel(cfg_rate_sel), .lane_link_up(lane_link_up), .lane_serdes_rst(lane_serdes_rst),
    .lane_ready(lane_ready), .flap_count(flap_count), .flap_clear(flap_clear)
  );

  assign dut_vec = {qpll_reset, qpll_fault, sfp_tx_disable, sfp_rs, lane_serdes_rst, lane_ready, flap_count};

  // Behavioural model state
  int       q_mode[2], q_t[2], q_run[2], q_retry[2];
  int       l_mode[NL], l_cnt[NL], l_flap[NL];
  bit       l_link[NL];
  bit [1:0] l_rs[NL];
  bit       d_last[NL][2], d_filt[NL][2];
  int       d_run[NL][2];

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      q_mode[p] = Q_RESET; q_t[p] = 0; q_run[p] = 0; q_retry[p] = 0;
    end
    for (int i = 0; i < NL; i++) begin
      l_mode[i] = L_DIS; l_cnt[i] = 0; l_flap[i] = 0; l_link[i] = 0; l_rs[i] = 2'b00;
      for (int k = 0; k < 2; k++) begin
        d_last[i][k] = 1'b1; d_filt[i][k] = 1'b1; d_run[i][k] = DB + 1;
      end
    end
  endtask

  task automatic model_step();
    bit pll0, los, abs, rc, raw;
    pll0 = (q_mode[0] == Q_LOCKED);
    for (int i = 0; i < NL; i++) begin
      los = d_filt[i][0];
      abs = d_filt[i][1];
      rc  = (cfg_rate_sel[2*i +: 2] != l_rs[i]);
      if (flap_clear[i]) l_flap[i] = 0;
      else if (l_link[i] && !lane_link_up[i] && l_mode[i] == L_ACT && l_flap[i] < (1 << FW) - 1)
        l_flap[i]++;
      l_link[i] = lane_link_up[i];
      l_rs[i]   = cfg_rate_sel[2*i +: 2];
      if (!cfg_lane_en[i]) l_mode[i] = L_DIS;
      else if (!pll0) l_mode[i] = L_WPLL;
      else if ((l_mode[i] == L_SRST || l_mode[i] == L_ACT) && (abs || los)) l_mode[i] = L_WSIG;
      else if (l_mode[i] == L_DIS) l_mode[i] = L_WPLL;
      else if (l_mode[i] == L_WPLL) l_mode[i] = L_WSIG;
      else if (l_mode[i] == L_WSIG) begin
        if (!abs && !los) begin l_mode[i] = L_SRST; l_cnt[i] = 0; end
      end else if (l_mode[i] == L_SRST) begin
        if (rc) l_cnt[i] = 0;
        else begin l_cnt[i]++; if (l_cnt[i] == 16) l_mode[i] = L_ACT; end
      end else if (rc) begin
        l_mode[i] = L_SRST; l_cnt[i] = 0;
      end
      for (int k = 0; k < 2; k++) begin
        raw = (k == 1) ? sfp_mod_abs[i] : sfp_rx_los[i];
        if (raw == d_last[i][k]) d_run[i][k] = (d_run[i][k] > DB) ? DB + 1 : d_run[i][k] + 1;
        else d_run[i][k] = 1;
        d_last[i][k] = raw;
        if (d_run[i][k] >= DB + 1) d_filt[i][k] = raw;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (q_mode[p] == Q_RESET) begin
        q_t[p]++;
        if (q_t[p] == 16) begin q_mode[p] = Q_WAIT; q_t[p] = 0; q_run[p] = 0; end
      end else if (q_mode[p] == Q_WAIT) begin
        q_t[p]++;
        q_run[p] = qpll_lock[p] ? q_run[p] + 1 : 0;
        if (q_run[p] == 64) begin q_mode[p] = Q_LOCKED; q_retry[p] = 0; end
        else if (q_t[p] == LT) begin
          q_retry[p]++;
          if (q_retry[p] == MR) q_mode[p] = Q_FAULT;
          else begin q_mode[p] = Q_RESET; q_t[p] = 0; end
        end
      end else if (q_mode[p] == Q_LOCKED && !qpll_lock[p]) begin
        q_mode[p] = Q_RESET; q_t[p] = 0;
      end
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [1:0]       qr, qf;
    logic [NL-1:0]    txd, srst, rdy;
    logic [2*NL-1:0]  rs;
    logic [FW*NL-1:0] fc;
    for (int p = 0; p < 2; p++) begin
      qr[p] = (q_mode[p] == Q_RESET);
      qf[p] = (q_mode[p] == Q_FAULT);
    end
    for (int i = 0; i < NL; i++) begin
`ifdef SFP_SUPERVISOR_TX_SQUELCH_EN
      txd[i] = !(l_mode[i] == L_SRST || l_mode[i] == L_ACT);
`else
      txd[i] = (l_mode[i] == L_DIS) || d_filt[i][1];
`endif
      srst[i] = (l_mode[i] != L_ACT);
      rdy[i]  = (l_mode[i] == L_ACT);
      rs[2*i +: 2] = l_rs[i];
      fc[FW*i +: FW] = FW'(l_flap[i]);
    end
    return {qr, qf, txd, rs, srst, rdy, fc};
  endfunction

  // Advance one clock; inputs are held across the edge, outputs are read at the falling edge.
  task automatic tick();
    @(posedge clk_sys);
    if (rst) model_reset();
    else model_step();
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int n = 0; n < 3; n++) begin
      cfg_rate_sel = 8'($urandom);
      tick();
      vectors++;
      if (sfp_rs !== '0) begin
        miscompares++; $display("FAIL reset_rs: got %h expected 0", sfp_rs);
      end
    end
    vectors++;
    if (qpll_reset !== 2'b11) begin miscompares++; $display("FAIL reset_qpll_reset: got %b expected 11", qpll_reset); end
    vectors++;
    if (qpll_fault !== 2'b00) begin miscompares++; $display("FAIL reset_qpll_fault: got %b expected 00", qpll_fault); end
    vectors++;
    if (lane_serdes_rst !== '1) begin miscompares++; $display("FAIL reset_serdes_rst: got %b expected 1111", lane_serdes_rst); end
    vectors++;
    if (lane_ready !== '0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0000", lane_ready); end
    vectors++;
    if (sfp_tx_disable !== '1) begin miscompares++; $display("FAIL reset_tx_disable: got %b expected 1111", sfp_tx_disable); end
    vectors++;
    if (flap_count !== '0) begin miscompares++; $display("FAIL reset_flap: got %h expected 0", flap_count); end
    cfg_rate_sel = '0;
  endtask

  task automatic test_lock_timeout();
    int runs[2];
    logic [1:0] prev;
    qpll_lock = 2'b00;
    rst = 1'b0;
    runs[0] = 1; runs[1] = 1; prev = 2'b11;
    for (int n = 0; n < 3 * (16 + LT) + 300; n++) begin
      tick();
      for (int p = 0; p < 2; p++) if (qpll_reset[p] && !prev[p]) runs[p]++;
      prev = qpll_reset;
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++; $display("FAIL timeout_model: got %h expected %h", dut_vec, model_vec());
      end
    end
    vectors++;
    if (runs[0] != MR || runs[1] != MR) begin
      miscompares++; $display("FAIL timeout_pulses: got %0d/%0d expected %0d", runs[0], runs[1], MR);
    end
    vectors++;
    if (qpll_fault !== 2'b11) begin miscompares++; $display("FAIL timeout_fault: got %b expected 11", qpll_fault); end
  endtask

  task automatic test_lock();
    int n;
    rst = 1'b1;
    model_reset();
    tick();
    qpll_lock = 2'b00;
    cfg_lane_en = 4'b0001;
    cfg_rate_sel = 8'h02;
    sfp_rx_los = 4'b1110;
    sfp_mod_abs = 4'b1110;
    rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (qpll_reset[0] && n < 100);
    vectors++;
    if (n != 16) begin miscompares++; $display("FAIL lock_reset_len: got %0d expected 16", n); end
    for (int k = 0; k < 100; k++) begin
      tick();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++; $display("FAIL lock_wait_model: got %h expected %h", dut_vec, model_vec());
      end
    end
    qpll_lock = 2'b11;
    n = 0;
    do begin
      tick(); n++;
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++; $display("FAIL lock_model: got %h expected %h", dut_vec, model_vec());
      end
    end while (!lane_ready[0] && n < 200);
    // 64 stable lock cycles, one cycle each into WAIT_SIGNAL and SERDES_RST, 16 reset cycles
    vectors++;
    if (n != 64 + 1 + 1 + 16) begin miscompares++; $display("FAIL lock_to_ready: got %0d expected 82", n); end
    vectors++;
    if (qpll_fault !== 2'b00) begin miscompares++; $display("FAIL lock_fault: got %b expected 00", qpll_fault); end
  endtask

  task automatic test_lane_bringup();
    int n;
    cfg_lane_en[0] = 1'b0;
    sfp_rx_los[0] = 1'b1;
    sfp_mod_abs[0] = 1'b1;
    repeat (12) tick();
    cfg_lane_en[0] = 1'b1;
    repeat (3) tick();
    vectors++;
    if (sfp_tx_disable[0] !== 1'b1) begin miscompares++; $display("FAIL bringup_absent_txdis: got %b expected 1", sfp_tx_disable[0]); end
    sfp_rx_los[0] = 1'b0;
    sfp_mod_abs[0] = 1'b0;
    n = 0;
    do begin
      tick(); n++;
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++; $display("FAIL bringup_model: got %h expected %h", dut_vec, model_vec());
      end
    end while (!lane_ready[0] && n < 100);
    // DB+1 equal samples to filter, one cycle to enter SERDES_RST, 16 cycles held
    vectors++;
    if (n != DB + 1 + 1 + 16) begin miscompares++; $display("FAIL bringup_latency: got %0d expected %0d", n, DB + 18); end
    vectors++;
    if (lane_serdes_rst[0] !== 1'b0) begin miscompares++; $display("FAIL bringup_serdes_rst: got %b expected 0", lane_serdes_rst[0]); end
    vectors++;
    if (sfp_tx_disable[3:1] !== 3'b111) begin miscompares++; $display("FAIL bringup_idle_txdis: got %b expected 111", sfp_tx_disable[3:1]); end
  endtask

  task automatic test_glitch();
    sfp_rx_los[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) sfp_rx_los[0] = 1'b0;
      tick();
      vectors++;
      if (lane_ready[0] !== 1'b1) begin miscompares++; $display("FAIL glitch_ready: cycle %0d got %b expected 1", k, lane_ready[0]); end
    end
  endtask

  task automatic test_flap();
    lane_link_up[0] = 1'b1;
    repeat (3) tick();
    for (int e = 0; e < 3; e++) begin
      lane_link_up[0] = 1'b0; repeat (2) tick();
      lane_link_up[0] = 1'b1; repeat (2) tick();
    end
    vectors++;
    if (flap_count[FW-1:0] !== 4'd3) begin miscompares++; $display("FAIL flap_three: got %0d expected 3", flap_count[FW-1:0]); end
    lane_link_up[0] = 1'b0;
    flap_clear[0] = 1'b1;
    tick();
    flap_clear[0] = 1'b0;
    vectors++;
    if (flap_count[FW-1:0] !== 4'd0) begin miscompares++; $display("FAIL flap_clear_wins: got %0d expected 0", flap_count[FW-1:0]); end
    lane_link_up[0] = 1'b1; repeat (2) tick();
    for (int e = 0; e < 20; e++) begin
      lane_link_up[0] = 1'b0; tick();
      lane_link_up[0] = 1'b1; tick();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++; $display("FAIL flap_model: got %h expected %h", dut_vec, model_vec());
      end
    end
    vectors++;
    if (flap_count[FW-1:0] !== 4'hF) begin miscompares++; $display("FAIL flap_saturate: got %0d expected 15", flap_count[FW-1:0]); end
  endtask

  task automatic test_pll_loss();
    int n;
    cfg_lane_en = '1;
    sfp_rx_los = '0;
    sfp_mod_abs = '0;
    repeat (40) tick();
    vectors++;
    if (lane_ready !== '1) begin miscompares++; $display("FAIL loss_all_active: got %b expected 1111", lane_ready); end
    qpll_lock[0] = 1'b0;
    tick();
    qpll_lock[0] = 1'b1;
    tick();
    vectors++;
    if (lane_ready !== '0 || lane_serdes_rst !== '1) begin
      miscompares++; $display("FAIL loss_drop: ready %b serdes_rst %b expected 0000/1111", lane_ready, lane_serdes_rst);
    end
    n = 0;
    do begin
      tick(); n++;
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++; $display("FAIL loss_model: got %h expected %h", dut_vec, model_vec());
      end
    end while (lane_ready !== '1 && n < 300);
    vectors++;
    if (lane_ready !== '1) begin miscompares++; $display("FAIL loss_recover: got %b expected 1111", lane_ready); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NL; i++) begin
        if ($urandom_range(0, 63) == 0) cfg_lane_en[i] = ~cfg_lane_en[i];
        if ($urandom_range(0, 63) == 0) cfg_rate_sel[2*i +: 2] = 2'($urandom);
        if ($urandom_range(0, 7) == 0) lane_link_up[i] = ~lane_link_up[i];
        flap_clear[i] = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 39) == 0) sfp_rx_los[i] = ~sfp_rx_los[i];
        if ($urandom_range(0, 59) == 0) sfp_mod_abs[i] = ~sfp_mod_abs[i];
      end
      qpll_lock[0] = ($urandom_range(0, 299) != 0);
      tick();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++; $display("FAIL random_model: cycle %0d got %h expected %h", n, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_timeout();
    test_lock();
    test_lane_bringup();
    test_glitch();
    test_flap();
    test_pll_loss();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sfp_quad_supervisor.md
Name: sfp_quad_supervisor

Overview:
Parametrised control and status supervisor for a GTY quad driving NUM_LANES SFP cages.
- Replaces hard tie-offs of tx_disable and rate select with per-lane sequencing.
- Supervises both QPLLs with lock timeout, retry and fault latching.
- Debounces module-absent and LOS inputs, sequences lane SERDES resets, and counts link flaps.
- Sits between the quad PLL, the per-lane MAC/PCS/bridge wrappers and the SFP cage pins.

Parameters:
NUM_LANES, 4, number of SFP lanes supervised (1..4)
DEBOUNCE_CYCLES, 156250, cycles a pin must be stable before being accepted (1 ms at 156.25 MHz)
LOCK_TIMEOUT, 1562500, cycles allowed for QPLL lock after reset release (10 ms)
MAX_RETRIES, 3, QPLL reset attempts before declaring fault
FLAP_WIDTH, 16, width of each per-lane link flap counter

Ports:
clk_sys  input  1  system clock; all logic is in this domain
rst  input  1  asynchronous active-high reset
qpll_lock  input  2  raw lock from QPLL0/QPLL1, pre-synchronised
qpll_reset  output  2  QPLL reset pulse request
qpll_fault  output  2  sticky: QPLL failed to lock after MAX_RETRIES
sfp_rx_los  input  NUM_LANES  raw LOS pin per lane
sfp_mod_abs  input  NUM_LANES  raw module-absent pin per lane
sfp_tx_disable  output  NUM_LANES  TX disable pin per lane
sfp_rs  output  2*NUM_LANES  rate select, two bits per lane
cfg_lane_en  input  NUM_LANES  software lane enable
cfg_rate_sel  input  2*NUM_LANES  requested rate select
lane_link_up  input  NUM_LANES  link status from each lane PCS
lane_serdes_rst  output  NUM_LANES  reset to lane transceiver datapath
lane_ready  output  NUM_LANES  lane is in ACTIVE
flap_count  output  FLAP_WIDTH*NUM_LANES  per-lane saturating link-down counter
flap_clear  input  NUM_LANES  synchronous clear of the matching flap counter

Behaviour:
- Reset values:
  - qpll_reset = 2'b11 during rst.
  - qpll_fault = 0; lane_serdes_rst = all 1; lane_ready = 0; flap_count = 0.
  - sfp_tx_disable = all 1; sfp_rs = 0.
- QPLL FSM (one per PLL, states RESET, WAIT_LOCK, LOCKED, FAULT):
  - RESET: drive qpll_reset for exactly 16 cycles, then go to WAIT_LOCK with timer = 0.
  - WAIT_LOCK: lock high for 64 consecutive cycles -> LOCKED. Timer reaching LOCK_TIMEOUT -> retries++; if retries == MAX_RETRIES go to FAULT, else go to RESET.
  - LOCKED: lock low for a single cycle -> RESET; retries clear.
  - FAULT: qpll_fault = 1; stays here until rst.
- Debounce (per pin):
  - Counter restarts on every change of the raw value.
  - The filtered value updates when the counter reaches DEBOUNCE_CYCLES-1.
  - Filtered values reset to 1 (absent / LOS).
- Lane FSM (one per lane, states DISABLED, WAIT_PLL, WAIT_SIGNAL, SERDES_RST, ACTIVE):
  - DISABLED: tx_disable = 1. When cfg_lane_en = 1 -> WAIT_PLL.
  - WAIT_PLL: wait for QPLL0 in LOCKED -> WAIT_SIGNAL.
  - WAIT_SIGNAL: tx_disable = mod_abs_filt. When !mod_abs_filt && !los_filt -> SERDES_RST.
  - SERDES_RST: lane_serdes_rst held for 16 cycles -> ACTIVE.
  - ACTIVE: lane_serdes_rst = 0; lane_ready = 1.
  - Priority of exits from any state, highest first: cfg_lane_en = 0 -> DISABLED; QPLL0 leaves LOCKED -> WAIT_PLL; mod_abs_filt or los_filt rises -> WAIT_SIGNAL.
  - lane_serdes_rst = 1 in every state except ACTIVE.
- sfp_rs:
  - Registered copy of cfg_rate_sel.
  - A rate change while ACTIVE forces SERDES_RST and restarts the 16-cycle count.
- Flap counter:
  - Increments on a falling edge of lane_link_up while the lane is ACTIVE.
  - Saturates at all ones.
  - flap_clear takes priority over a same-cycle increment; the result is 0.
- Lanes at index NUM_LANES and above do not exist. QPLL1 is supervised but never gates lanes.

Optional Feature:
Macro SFP_SUPERVISOR_TX_SQUELCH_EN.
- Defined: sfp_tx_disable = 1 in every state except SERDES_RST and ACTIVE, so the laser stays dark until signal and PLL are good.
- Undefined: tx_disable depends only on DISABLED and mod_abs_filt, as described under Behaviour.

Decomposition:
- Package sfp_supervisor_pkg holds:
  - enums qpll_state_t and lane_state_t;
  - localparams RESET_PULSE_CYCLES = 16 and LOCK_STABLE_CYCLES = 64.
- Sub-module sfp_lane_fsm: one instance per lane via generate; contains the two debouncers, the lane FSM and the flap counter.
- The QPLL FSMs stay in the top level.

Test Plan:
- Lock behaviour: assert rst, release, raise qpll_lock[0] 100 cycles after qpll_reset drops. Require exactly 16 reset cycles, LOCKED after 64 more cycles, qpll_fault = 0.
- Lock never asserts (DEBOUNCE_CYCLES=8, LOCK_TIMEOUT=200): require 3 qpll_reset pulses, then qpll_fault[0] = 1 and no further pulses.
- Lane bring-up: cfg_lane_en = 4'b0001, mod_abs = 0 and los = 0 stable. Require lane_serdes_rst[0] to fall 16 cycles after debounce completes and lane_ready[0] = 1; lanes 1-3 keep tx_disable = 1.
- Glitch rejection: toggle los[0] for 5 cycles (< DEBOUNCE_CYCLES=8) while ACTIVE. Require lane_ready[0] to stay 1.
- Flap counting: 3 link_up falling edges while ACTIVE -> flap_count[0] = 3. flap_clear coincident with a 4th edge -> 0. Preload FLAP_WIDTH=4 and apply 20 edges -> counter holds at 15.
- PLL loss: drop qpll_lock[0] for 1 cycle while lanes are ACTIVE. Require all lanes to return to WAIT_PLL with lane_serdes_rst = 1, then recover after relock.
